// File: rtl/tick_blink_indicator.sv
// tick_blink_indicator: turns one-cycle tick pulses into visible LED blinks.
// Ticks that arrive mid-blink are queued in a saturating counter and replayed.
module tick_blink_indicator #(
   parameter int ON_CYCLES   = 250000,
   parameter int OFF_CYCLES  = 250000,
   parameter int MAX_PENDING = 15
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic                               tick_i,
   output logic                               led_o,
   output logic                               busy_o,
   output logic [$clog2(MAX_PENDING+1)-1:0]   pending_o,
   output logic                               drop_o
);
   localparam int CMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int PW   = $clog2(MAX_PENDING + 1);
   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;
   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [PW-1:0]   pend_n;
   logic            drop_n, last_on, last_off, full, queue;
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state     <= S_IDLE;
         cnt       <= '0;
         pending_o <= '0;
         drop_o    <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         pending_o <= pend_n;
         drop_o    <= drop_n;
      end
   end
   // A tick on the last OFF cycle either starts the next blink directly or
   // cancels against the pending decrement, so it is never queued there.
   always_comb begin
      last_on  = (state == S_ON)  && (cnt == CW'(ON_CYCLES - 1));
      last_off = (state == S_OFF) && (cnt == CW'(OFF_CYCLES - 1));
      full     = (pending_o == PW'(MAX_PENDING));
      queue    = tick_i && (state == S_ON || state == S_OFF) && !last_off;
      state_n  = (state == S_ON)  ? (last_on ? S_OFF : S_ON) :
                 (state == S_OFF) ? (last_off ? ((tick_i || pending_o != '0) ? S_ON : S_IDLE) : S_OFF) :
                 (tick_i ? S_ON : S_IDLE);
      cnt_n    = (state == S_ON || state == S_OFF) && !last_on && !last_off ? cnt + CW'(1) : '0;
      pend_n   = (last_off && !tick_i && pending_o != '0) ? pending_o - PW'(1) :
                 (queue && !full) ? pending_o + PW'(1) : pending_o;
      drop_n   = queue && full;
   end
   always_comb begin
      led_o  = (state == S_ON);
      busy_o = (state != S_IDLE);
   end
endmodule

// File: tb/tb_tick_blink_indicator.sv
// tb_tick_blink_indicator: directed scenarios with hand-derived cycle timelines.
module tb_tick_blink_indicator;
   logic       clk = 1'b0;
   logic       reset_i = 1'b1;
   logic       tick_i = 1'b0;
   logic       led_o, busy_o, drop_o;
   logic [1:0] pending_o;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   tick_blink_indicator #(.ON_CYCLES(4), .OFF_CYCLES(3), .MAX_PENDING(2)) dut (
      .clk_i(clk), .reset_i(reset_i), .tick_i(tick_i),
      .led_o(led_o), .busy_o(busy_o), .pending_o(pending_o), .drop_o(drop_o)
   );

   always #5 clk = ~clk;

   // Applies inputs for the current cycle, then advances to the next one.
   task automatic step(input logic t, input logic r);
      tick_i  = t;
      reset_i = r;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      tick_i  = 1'b0;
      reset_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset_i = 1'b0;
      cyc = 0;
   endtask

   function automatic logic in_rng(int c, int lo, int hi);
      return (c >= lo) && (c <= hi);
   endfunction

   task automatic test_reset();
      logic [4:0] exp_v;
      do_reset();
      exp_v = 5'b0;
      checks++;
      if ({led_o, busy_o, pending_o, drop_o} !== exp_v) begin
         errors++;
         $display("FAIL reset: got led/busy/pend/drop=%b, want %b", {led_o, busy_o, pending_o, drop_o}, exp_v);
      end
   endtask

   task automatic test_single();
      logic [4:0] exp_v;
      do_reset();
      for (int c = 0; c <= 10; c++) begin
         exp_v = {in_rng(c, 1, 4), in_rng(c, 1, 7), 2'd0, 1'b0};
         checks++;
         if ({led_o, busy_o, pending_o, drop_o} !== exp_v) begin
            errors++;
            $display("FAIL single cycle %0d: got %b, want %b", c, {led_o, busy_o, pending_o, drop_o}, exp_v);
         end
         step(c == 0, 1'b0);
      end
   endtask

   task automatic test_queue();
      logic [4:0] exp_v;
      logic [1:0] p;
      do_reset();
      for (int c = 0; c <= 24; c++) begin
         p = (c == 2) ? 2'd1 : in_rng(c, 3, 7) ? 2'd2 : in_rng(c, 8, 14) ? 2'd1 : 2'd0;
         exp_v = {in_rng(c, 1, 4) || in_rng(c, 8, 11) || in_rng(c, 15, 18), in_rng(c, 1, 21), p, 1'b0};
         checks++;
         if ({led_o, busy_o, pending_o, drop_o} !== exp_v) begin
            errors++;
            $display("FAIL queue cycle %0d: got %b, want %b", c, {led_o, busy_o, pending_o, drop_o}, exp_v);
         end
         step(c <= 2, 1'b0);
      end
   endtask

   task automatic test_overflow();
      logic [4:0] exp_v;
      logic [1:0] p;
      int         rises = 0;
      logic       prev = 1'b0;
      do_reset();
      for (int c = 0; c <= 24; c++) begin
         p = (c == 2) ? 2'd1 : in_rng(c, 3, 7) ? 2'd2 : in_rng(c, 8, 14) ? 2'd1 : 2'd0;
         exp_v = {in_rng(c, 1, 4) || in_rng(c, 8, 11) || in_rng(c, 15, 18), in_rng(c, 1, 21), p, c == 4 || c == 5};
         checks++;
         if ({led_o, busy_o, pending_o, drop_o} !== exp_v) begin
            errors++;
            $display("FAIL overflow cycle %0d: got %b, want %b", c, {led_o, busy_o, pending_o, drop_o}, exp_v);
         end
         if (led_o && !prev) rises++;
         prev = led_o;
         step(c <= 4, 1'b0);
      end
      checks++;
      if (rises != 3) begin
         errors++;
         $display("FAIL overflow blink count: got %0d, want 3", rises);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] exp_v;
      do_reset();
      for (int c = 0; c <= 16; c++) begin
         exp_v = {in_rng(c, 1, 4) || in_rng(c, 8, 11), in_rng(c, 1, 14), 2'd0, 1'b0};
         checks++;
         if ({led_o, busy_o, pending_o, drop_o} !== exp_v) begin
            errors++;
            $display("FAIL back_to_back cycle %0d: got %b, want %b", c, {led_o, busy_o, pending_o, drop_o}, exp_v);
         end
         step(c == 0 || c == 7, 1'b0);
      end
   endtask

   task automatic test_reset_mid();
      logic [4:0] exp_v;
      do_reset();
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      checks++;
      if (pending_o !== 2'd1) begin
         errors++;
         $display("FAIL reset_mid pre-reset pending: got %0d, want 1", pending_o);
      end
      step(1'b0, 1'b1);
      for (int c = 3; c <= 14; c++) begin
         exp_v = 5'b0;
         checks++;
         if ({led_o, busy_o, pending_o, drop_o} !== exp_v) begin
            errors++;
            $display("FAIL reset_mid cycle %0d: got %b, want %b", c, {led_o, busy_o, pending_o, drop_o}, exp_v);
         end
         step(1'b0, 1'b0);
      end
   endtask

   task automatic test_reset_tick();
      do_reset();
      step(1'b1, 1'b1);
      for (int c = 1; c <= 3; c++) begin
         checks++;
         if ({led_o, busy_o, pending_o, drop_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_tick cycle %0d: got %b, want 00000", c, {led_o, busy_o, pending_o, drop_o});
         end
         step(1'b0, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_queue();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      test_reset_tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/tick_blink_indicator.md
Name: tick_blink_indicator

Overview:
- Output-side counterpart to the button debouncer: consumes one-cycle tick pulses (e.g. a debounced button tick_o) and renders each tick as one human-visible LED blink.
- Ticks that arrive while a blink is in progress are queued in a saturating pending counter and replayed as back-to-back blinks.
- Sits between tick producers (debouncers, counters) and board LED pins.

Parameters:
- ON_CYCLES, 250000, clock cycles led_o is high per blink (>=1)
- OFF_CYCLES, 250000, clock cycles led_o is forced low after each blink (>=1)
- MAX_PENDING, 15, maximum queued ticks not yet blinked (>=1)

Ports:
- clk_i  input  1  system clock
- reset_i  input  1  synchronous, active-high reset
- tick_i  input  1  tick request; every cycle sampled high counts as one tick
- led_o  output  1  registered LED drive, high during blink ON phase
- busy_o  output  1  high whenever the FSM is not IDLE
- pending_o  output  $clog2(MAX_PENDING+1)  queued ticks not yet started
- drop_o  output  1  one-cycle pulse: a tick was discarded because the queue was full

Behaviour:
- One clock (clk_i); reset is synchronous and active-high (reset_i); all state updates on posedge clk_i.
- Reset values: state IDLE, led_o=0, busy_o=0, pending_o=0, drop_o=0, phase counter=0.
- Phase counter width: $clog2(max(ON_CYCLES,OFF_CYCLES)+1).
- All outputs are registered or decoded directly from registered state. There is no combinational path from tick_i to any output.
- FSM states:
  - IDLE
    - tick_i=1 -> ON next cycle, counter=0, pending unchanged.
    - Otherwise stay in IDLE.
    - Latency: tick in cycle N gives led_o=1 in cycle N+1.
  - ON
    - led_o=1 and counter increments each cycle.
    - When counter==ON_CYCLES-1 -> OFF, counter=0.
    - led_o is high for exactly ON_CYCLES cycles.
  - OFF
    - led_o=0 and counter increments each cycle.
    - On the last OFF cycle (counter==OFF_CYCLES-1):
      - pending>0 or tick_i=1 -> ON, counter=0.
      - Otherwise -> IDLE.
    - led_o is low for exactly OFF_CYCLES cycles between blinks.
- Pending counter:
  - tick_i=1 in ON or OFF, other than a tick consumed directly on the last OFF cycle -> pending+1.
  - If pending==MAX_PENDING, pending is unchanged and drop_o=1 in the next cycle.
  - Last OFF cycle, pending>0, tick_i=0 -> pending-1, start blink.
  - Last OFF cycle, pending>0, tick_i=1 -> pending unchanged (inc and dec cancel), start blink. No drop is possible in this case.
  - Last OFF cycle, pending==0, tick_i=1 -> tick consumed directly, pending stays 0, start blink.
- busy_o = (state != IDLE).
- drop_o never stays high for more than one cycle per dropped tick. Consecutive drops give consecutive high cycles.
- Reset mid-operation: regardless of state, the next cycle shows led_o=0, pending_o=0, busy_o=0, drop_o=0. No queued blink replays after reset.
- Counter never wraps: it is bounded by ON_CYCLES-1 / OFF_CYCLES-1.

Test Plan:
All scenarios use ON_CYCLES=4, OFF_CYCLES=3, MAX_PENDING=2, with cycle 0 = first cycle after reset is released.
- Single tick at cycle 0 -> led_o=1 cycles 1-4, 0 from cycle 5; busy_o=1 cycles 1-7, 0 at cycle 8; pending_o stays 0.
- Ticks at cycles 0,1,2 -> pending_o=1 at cycle 2 and 2 at cycle 3. Blinks: led high cycles 1-4, 8-11, 15-18. pending_o drops to 1 at cycle 8 and 0 at cycle 15. busy_o falls at cycle 22. drop_o never asserts.
- tick_i held high cycles 0-4 -> blink starts cycle 1, pending_o reaches 2, drop_o=1 at cycles 4 and 5. Exactly three blinks total.
- Single tick at cycle 0, second tick at cycle 7 (last OFF cycle) -> led_o=1 cycles 8-11 with no IDLE gap (busy_o stays 1); pending_o remains 0 throughout.
- Ticks at cycles 0,1, then reset_i=1 at cycle 2 -> cycle 3 shows led_o=0, pending_o=0, busy_o=0. No further blinks without new ticks.
- Tick in IDLE with reset_i=1 in the same cycle -> reset wins: led_o stays 0 and state stays IDLE.
